seq_arith_unit: RTL
===================

# seq_arith_unit

- Parametrised, handshaked arithmetic unit; one operation per transaction on W-bit unsigned operands, 2W-bit result plus status flags.
- Supported ops: add, subtract, multiply, divide, modulus, power.
- Add/sub/mul complete in one cycle; divide/modulus/power iterate over W cycles.
- Sits between an operand-producing stage and a result consumer. Both sides use valid/ready handshakes.

## Interface
- W, 4, operand width in bits; legal range 2..16.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  unit can accept (high only in IDLE)
- in_op  in  3  operation code (arith_pkg)
- in_a  in  W  operand a
- in_b  in  W  operand b (divisor / exponent)
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_result  out  2W  result
- out_zero  out  1  out_result == 0
- out_neg  out  1  SUB with a < b
- out_dbz  out  1  DIV/MOD with b == 0
- out_ovf  out  1  POW true value ≥ 2^(2W)
- out_err  out  1  illegal or compiled-out op

## Operation
- Op codes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 POW, 6–7 illegal.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1.
  - On in_valid & in_ready, latch op/a/b.
  - ADD/SUB/MUL/illegal go to DONE.
  - DIV/MOD/POW go to BUSY, iteration counter = 0.
- BUSY: one iteration per cycle. After iteration W−1 completes, go to DONE.
- DONE: out_valid=1; outputs are stable. On out_ready, go to IDLE.
- Width rules (operands zero-extended to 2W):
  - ADD: a+b. Never overflows.
  - SUB: (a−b) mod 2^(2W), i.e. sign-extended two's complement; out_neg=1 when a<b.
  - MUL: full a*b.
- DIV/MOD: restoring division, one quotient bit per cycle, MSB first.
  - Quotient and remainder are zero-extended to 2W.
  - b==0: DIV result = {W'0, W'1s}, MOD result = a, out_dbz=1. Still takes W BUSY cycles.
- POW: square-and-multiply over the exponent bits, MSB first, acc initialised to 1.
  - Per cycle: acc = acc², then acc = acc·a if the current exponent bit is set.
  - Products are formed at 4W bits and truncated to 2W.
  - out_ovf is sticky: set if any truncation discards a nonzero bit.
  - b==0 gives result 1.
- Illegal op: result 0, out_err=1, out_zero=1.
- out_zero is derived from the registered result for every op.
- Flags not relevant to the op are 0.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0, all flags 0.
- Latency (accept edge → out_valid high):
  - ADD/SUB/MUL/illegal: 1 cycle.
  - DIV/MOD/POW: W+1 cycles.
- Result and flags are registered. They change only on entry to DONE.
- in_ready is low in BUSY and DONE. Inputs are ignored there, even if in_valid is high.
- out_ready held low: DONE persists indefinitely and the result holds.
- Result accept cycle: in_ready stays 0 that cycle, so there is no same-cycle accept of a new op. Peak throughput is one op per 2 cycles (short ops).
- rst_n asserted mid-BUSY or mid-DONE: immediately returns to reset values. The partial result is discarded.
- in_op/in_a/in_b may change freely once accepted.

## Configuration
- ARITH_POW_EN defined: POW is implemented as above.
- ARITH_POW_EN undefined:
  - POW logic and the 4W-bit multipliers are removed.
  - Op 5 is treated as illegal: 1-cycle latency, result 0, out_err=1.

## Structure
- arith_pkg holds:
  - arith_op_e enum with the codes above.
  - State enum.
  - Localparam helpers for result width (2*W).
- Sub-module arith_divider: iterative restoring divider.
  - Ports: start, dividend, divisor, done, quotient, remainder, dbz.
  - Shared by DIV and MOD.
- Top level holds the FSM, the single-cycle datapath and the POW iterator.

## Test plan
- W=4, reset then ADD a=10 b=5 → 1 cycle later out_result=15, out_zero=0; out_ready=1 → IDLE.
- SUB a=3 b=9 → out_result=8'hFA, out_neg=1. SUB a=6 b=6 → result 0, out_zero=1.
- MUL a=15 b=7 → 105. DIV a=15 b=7 → 2 after 5 cycles. MOD a=15 b=7 → 1. DIV a=10 b=0 → 8'h0F with out_dbz=1; MOD a=10 b=0 → 10 with out_dbz=1.
- POW (ARITH_POW_EN):
  - a=3 b=9 → 227 with out_ovf=1.
  - a=6 b=2 → 36 with out_ovf=0.
  - a=5 b=0 → 1.
  - Build without the macro: op 5 → out_err=1, result 0, 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles after MUL 15*7 → result stays 105; in_ready=0 throughout; new in_valid ignored.
- Reset mid-op: deassert rst_n during BUSY of DIV 15/7 → immediate IDLE, out_valid=0. A following ADD 1+1 returns 2.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types for the sequential arithmetic unit: op codes, FSM states
// and the result-width helper.
package arith_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_MOD = 3'd4,
      OP_POW = 3'd5
   } arith_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int RES_MULT = 2;

   function automatic int res_width(input int w);
      return RES_MULT * w;
   endfunction

endpackage

// File: rtl/arith_divider.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// quotient/remainder/done show the final iteration's values combinationally.
module arith_divider #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         dbz
);

   localparam int CW = $clog2(W);

   logic          r_busy;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_q;
   logic [W-1:0]  r_rem;
   logic [W-1:0]  r_d;

   logic [W:0]    w_shift;
   logic          w_ge;
   logic [W-1:0]  w_rem_next;
   logic [W-1:0]  w_q_next;

   // A zero divisor always compares ge, giving all-ones quotient and rem == dividend.
   assign w_shift    = {r_rem, r_q[W-1]};
   assign w_ge       = (w_shift >= {1'b0, r_d});
   assign w_rem_next = w_ge ? (w_shift[W-1:0] - r_d) : w_shift[W-1:0];
   assign w_q_next   = {r_q[W-2:0], w_ge};

   assign done      = r_busy & (r_cnt == CW'(W-1));
   assign quotient  = w_q_next;
   assign remainder = w_rem_next;
   assign dbz       = (r_d == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_q    <= '0;
         r_rem  <= '0;
         r_d    <= '0;
      end else if (start) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_q    <= dividend;
         r_rem  <= '0;
         r_d    <= divisor;
      end else if (r_busy) begin
         r_cnt  <= r_cnt + 1'b1;
         r_q    <= w_q_next;
         r_rem  <= w_rem_next;
         if (done) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_arith_unit.sv
// Handshaked arithmetic unit: FSM, single-cycle datapath and POW iterator.
// Define ARITH_POW_EN to build the POW operation; otherwise op 5 is illegal.
module seq_arith_unit
   import arith_pkg::*;
#(
   parameter int W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          in_op,
   input  logic [W-1:0]        in_a,
   input  logic [W-1:0]        in_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*W-1:0]      out_result,
   output logic                out_zero,
   output logic                out_neg,
   output logic                out_dbz,
   output logic                out_ovf,
   output logic                out_err
);

   localparam int RW = res_width(W);

   state_e        r_state, w_state_next;
   logic [2:0]    r_op;
   logic [RW-1:0] r_result;
   logic          r_zero, r_neg, r_dbz, r_ovf, r_err;

   logic          w_accept, w_in_long, w_start_div, w_r_isdiv, w_last;
   logic [RW-1:0] w_short_res, w_long_res, w_pow_res;
   logic          w_short_neg, w_short_err, w_pow_last, w_pow_ovf;
   logic          w_div_done, w_div_dbz;
   logic [W-1:0]  w_quot, w_rem;

   assign w_accept    = in_valid & in_ready;
   assign w_start_div = w_accept & ((in_op == OP_DIV) | (in_op == OP_MOD));
   assign w_r_isdiv   = (r_op == OP_DIV) | (r_op == OP_MOD);
   assign w_last      = w_r_isdiv ? w_div_done : w_pow_last;

`ifdef ARITH_POW_EN
   localparam int QW = 4 * W;
   localparam int CW = $clog2(W);

   logic [RW-1:0] r_acc;
   logic          r_acc_ovf;
   logic [W-1:0]  r_a, r_exp;
   logic [CW-1:0] r_cnt;
   logic [QW-1:0] w_sq, w_mul;
   logic          w_bit;

   assign w_in_long  = (in_op == OP_DIV) | (in_op == OP_MOD) | (in_op == OP_POW);
   assign w_bit      = r_exp[W-1];
   assign w_sq       = QW'(r_acc) * QW'(r_acc);
   assign w_mul      = QW'(w_sq[RW-1:0]) * QW'(r_a);
   assign w_pow_res  = w_bit ? w_mul[RW-1:0] : w_sq[RW-1:0];
   assign w_pow_ovf  = r_acc_ovf | (|w_sq[QW-1:RW]) | (w_bit & (|w_mul[QW-1:RW]));
   assign w_pow_last = (r_cnt == CW'(W-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_acc_ovf <= 1'b0;
         r_a       <= '0;
         r_exp     <= '0;
         r_cnt     <= '0;
      end else if (w_accept) begin
         r_acc     <= RW'(1);
         r_acc_ovf <= 1'b0;
         r_a       <= in_a;
         r_exp     <= in_b;
         r_cnt     <= '0;
      end else if (r_state == ST_BUSY) begin
         r_acc     <= w_pow_res;
         r_acc_ovf <= w_pow_ovf;
         r_exp     <= {r_exp[W-2:0], 1'b0};
         r_cnt     <= r_cnt + 1'b1;
      end
   end
`else
   assign w_in_long  = (in_op == OP_DIV) | (in_op == OP_MOD);
   assign w_pow_res  = '0;
   assign w_pow_ovf  = 1'b0;
   assign w_pow_last = 1'b0;
`endif

   arith_divider #(.W(W)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (w_start_div),
      .dividend  (in_a),
      .divisor   (in_b),
      .done      (w_div_done),
      .quotient  (w_quot),
      .remainder (w_rem),
      .dbz       (w_div_dbz)
   );

   always_comb begin
      w_short_res = '0;
      w_short_neg = 1'b0;
      w_short_err = 1'b0;
      case (in_op)
         OP_ADD:  w_short_res = RW'(in_a) + RW'(in_b);
         OP_SUB: begin
            w_short_res = RW'(in_a) - RW'(in_b);
            w_short_neg = (in_a < in_b);
         end
         OP_MUL:  w_short_res = RW'(in_a) * RW'(in_b);
         default: w_short_err = 1'b1;
      endcase
   end

   always_comb begin
      w_long_res = w_pow_res;
      if (r_op == OP_DIV) begin
         w_long_res = RW'(w_quot);
      end else if (r_op == OP_MOD) begin
         w_long_res = RW'(w_rem);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_next = w_in_long ? ST_BUSY : ST_DONE;
         ST_BUSY: if (w_last)   w_state_next = ST_DONE;
         ST_DONE: if (out_ready) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
   end

   // Result and flags only move on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_neg    <= 1'b0;
         r_dbz    <= 1'b0;
         r_ovf    <= 1'b0;
         r_err    <= 1'b0;
      end else if (w_accept) begin
         r_op <= in_op;
         if (!w_in_long) begin
            r_result <= w_short_res;
            r_zero   <= (w_short_res == '0);
            r_neg    <= w_short_neg;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= w_short_err;
         end
      end else if ((r_state == ST_BUSY) && w_last) begin
         r_result <= w_long_res;
         r_zero   <= (w_long_res == '0);
         r_neg    <= 1'b0;
         r_dbz    <= w_r_isdiv & w_div_dbz;
         r_ovf    <= ~w_r_isdiv & w_pow_ovf;
         r_err    <= 1'b0;
      end
   end

   assign out_result = r_result;
   assign out_zero   = r_zero;
   assign out_neg    = r_neg;
   assign out_dbz    = r_dbz;
   assign out_ovf    = r_ovf;
   assign out_err    = r_err;

endmodule
